// File: rtl/c7458_edge_monitor.sv
// Edge monitor for the two c7458 AND-OR outputs: glitch-filters each line, counts
// filtered rising edges and queues every filtered edge as a timestamped event.
module c7458_edge_monitor #(
    parameter int STABLE = 2,
    parameter int CNT_W  = 8,
    parameter int TS_W   = 8,
    parameter int DEPTH  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             p1y,
    input  logic             p2y,
    input  logic             clr,
    output logic             f1y,
    output logic             f2y,
    output logic [CNT_W-1:0] cnt1,
    output logic [CNT_W-1:0] cnt2,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [TS_W+1:0]  evt_data,
    output logic             overflow
);

    localparam int RW = $clog2(STABLE + 1);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = TS_W + 2;

    logic [1:0]      w_raw;
    logic [1:0]      w_flip;
    logic [1:0]      r_f;
    logic [RW-1:0]   r_run [2];
    logic [TS_W-1:0] r_ts;

    logic [EW-1:0]   r_mem [DEPTH];
    logic [AW-1:0]   r_rd;
    logic [AW-1:0]   r_wr;
    logic [AW:0]     r_count;

    logic [EW-1:0]   w_evt1;
    logic [EW-1:0]   w_evt2;
    logic            w_pop;
    logic [AW:0]     w_free;
    logic            w_acc1;
    logic            w_acc2;
    logic            w_drop;
    logic [AW:0]     w_npush;

    assign w_raw = {p2y, p1y};

    // A line flips on the sample that completes STABLE consecutive disagreements.
    always_comb begin
        w_flip = '0;
        for (int ch = 0; ch < 2; ch++) begin
            w_flip[ch] = (w_raw[ch] != r_f[ch]) &&
                         ((r_run[ch] + RW'(1)) == RW'(STABLE));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_f      <= '0;
            r_run[0] <= '0;
            r_run[1] <= '0;
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                if (w_raw[ch] == r_f[ch]) begin
                    r_run[ch] <= '0;
                end else if (w_flip[ch]) begin
                    r_f[ch]   <= w_raw[ch];
                    r_run[ch] <= '0;
                end else begin
                    r_run[ch] <= r_run[ch] + RW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ts <= '0;
        end else begin
            r_ts <= r_ts + TS_W'(1);
        end
    end

    // The event stamp is the cycle of the final qualifying sample, i.e. the current ts.
    assign w_evt1 = {1'b0, p1y, r_ts};
    assign w_evt2 = {1'b1, p2y, r_ts};

    assign w_pop   = evt_valid && evt_ready;
    assign w_free  = (AW+1)'(DEPTH) - r_count + {{AW{1'b0}}, w_pop};
    assign w_acc1  = w_flip[0] && (w_free != '0);
    assign w_acc2  = w_flip[1] && (w_free >= (w_acc1 ? (AW+1)'(2) : (AW+1)'(1)));
    assign w_drop  = (w_flip[0] && !w_acc1) || (w_flip[1] && !w_acc2);
    assign w_npush = {{AW{1'b0}}, w_acc1} + {{AW{1'b0}}, w_acc2};

    // Channel 1 always lands first; a popped slot may be reused in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (w_acc1) begin
                r_mem[r_wr] <= w_evt1;
            end
            if (w_acc2) begin
                r_mem[r_wr + AW'(w_acc1)] <= w_evt2;
            end
            r_wr    <= r_wr + AW'(w_npush);
            r_rd    <= r_rd + AW'(w_pop);
            r_count <= r_count + w_npush - {{AW{1'b0}}, w_pop};
        end
    end

    assign evt_valid = (r_count != '0);
    assign evt_data  = r_mem[r_rd];

    // Clear has priority over a same-cycle increment or drop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt1     <= '0;
            cnt2     <= '0;
            overflow <= 1'b0;
        end else if (clr) begin
            cnt1     <= '0;
            cnt2     <= '0;
            overflow <= 1'b0;
        end else begin
            if (w_flip[0] && p1y && (cnt1 != '1)) begin
                cnt1 <= cnt1 + CNT_W'(1);
            end
            if (w_flip[1] && p2y && (cnt2 != '1)) begin
                cnt2 <= cnt2 + CNT_W'(1);
            end
            if (w_drop) begin
                overflow <= 1'b1;
            end
        end
    end

    assign f1y = r_f[0];
    assign f2y = r_f[1];

endmodule

// File: tb/tb_c7458_edge_monitor.sv
// Randomized and directed bench for c7458_edge_monitor against a queue-based
// reference model of the filters, counters and event FIFO.
module tb_c7458_edge_monitor;

    localparam int STABLE = 2;
    localparam int CNT_W  = 8;
    localparam int TS_W   = 8;
    localparam int DEPTH  = 4;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst_n;
    logic             p1y;
    logic             p2y;
    logic             clr;
    logic             f1y;
    logic             f2y;
    logic [CNT_W-1:0] cnt1;
    logic [CNT_W-1:0] cnt2;
    logic             evt_valid;
    logic             evt_ready;
    logic [TS_W+1:0]  evt_data;
    logic             overflow;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int              mF [2];
    int              mStreak [2];
    int              mCnt [2];
    int              mTs;
    bit              mOv;
    logic [TS_W+1:0] mQ [$];

    bit curP1, curP2;

    c7458_edge_monitor #(
        .STABLE(STABLE), .CNT_W(CNT_W), .TS_W(TS_W), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .p1y(p1y), .p2y(p2y), .clr(clr),
        .f1y(f1y), .f2y(f2y), .cnt1(cnt1), .cnt2(cnt2),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_data(evt_data),
        .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // One clock: drive inputs, advance the model by the behavioural rules, compare after the edge.
    task automatic applyStimulus(input bit a1, input bit a2, input bit c, input bit rdy, input bit rn);
        bit raw [2];
        bit drop;
        logic [TS_W+1:0] ev;
        p1y = a1; p2y = a2; clr = c; evt_ready = rdy; rst_n = rn;
        raw[0] = a1; raw[1] = a2;
        if (!rn) begin
            for (int ch = 0; ch < 2; ch++) begin
                mF[ch] = 0; mStreak[ch] = 0; mCnt[ch] = 0;
            end
            mTs = 0; mOv = 0;
            mQ.delete();
        end else begin
            if (mQ.size() > 0 && rdy) void'(mQ.pop_front());
            drop = 0;
            for (int ch = 0; ch < 2; ch++) begin
                if (int'(raw[ch]) != mF[ch]) mStreak[ch]++;
                else mStreak[ch] = 0;
                if (mStreak[ch] >= STABLE) begin
                    mF[ch] = int'(raw[ch]);
                    mStreak[ch] = 0;
                    ev = {(ch == 1), raw[ch], TS_W'(mTs)};
                    if (mQ.size() < DEPTH) mQ.push_back(ev);
                    else drop = 1;
                    if (raw[ch] && mCnt[ch] < CMAX) mCnt[ch]++;
                end
            end
            if (drop) mOv = 1;
            if (c) begin
                mCnt[0] = 0; mCnt[1] = 0; mOv = 0;
            end
            mTs = (mTs + 1) % (1 << TS_W);
        end
        @(posedge clk);
        #1;
        checkOutput("f1y", 32'(f1y), 32'(mF[0]));
        checkOutput("f2y", 32'(f2y), 32'(mF[1]));
        checkOutput("cnt1", 32'(cnt1), 32'(mCnt[0]));
        checkOutput("cnt2", 32'(cnt2), 32'(mCnt[1]));
        checkOutput("overflow", 32'(overflow), 32'(mOv));
        checkOutput("evt_valid", 32'(evt_valid), 32'(mQ.size() != 0));
        if (mQ.size() != 0) checkOutput("evt_data", 32'(evt_data), 32'(mQ[0]));
        if (!rn) checkOutput("reset evt_data", 32'(evt_data), 32'd0);
    endtask

    task automatic holdCycles(input bit a1, input bit a2, input bit rdy, input int n);
        for (int i = 0; i < n; i++) applyStimulus(a1, a2, 1'b0, rdy, 1'b1);
    endtask

    initial begin
        p1y = 0; p2y = 0; clr = 0; evt_ready = 0; rst_n = 0;

        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);

        // p1y rises in the ts=5 cycle, flips at the edge ending ts=6
        holdCycles(0, 0, 0, 5);
        holdCycles(1, 0, 0, 2);
        checkOutput("first rise valid", 32'(evt_valid), 32'd1);
        checkOutput("first rise data", 32'(evt_data), 32'h106);
        checkOutput("first rise cnt1", 32'(cnt1), 32'd1);

        // one-cycle glitch on p2y at ts=10
        holdCycles(1, 0, 1, 3);
        holdCycles(1, 1, 1, 1);
        holdCycles(1, 0, 1, 1);
        checkOutput("glitch f2y", 32'(f2y), 32'd0);
        checkOutput("glitch cnt2", 32'(cnt2), 32'd0);

        // both lines rise in the ts=20 cycle, flip with stamp 21
        holdCycles(0, 0, 1, 8);
        holdCycles(1, 1, 1, 2);
        checkOutput("dual head ch1", 32'(evt_data), 32'h115);
        holdCycles(1, 1, 1, 1);
        checkOutput("dual head ch2", 32'(evt_data), 32'h315);
        checkOutput("dual cnt1", 32'(cnt1), 32'd2);
        checkOutput("dual cnt2", 32'(cnt2), 32'd1);
        holdCycles(1, 1, 1, 2);

        // stalled consumer: three queued, then a dual flip drops the channel 2 event
        holdCycles(0, 1, 0, 3);
        holdCycles(1, 1, 0, 3);
        holdCycles(0, 1, 0, 3);
        holdCycles(1, 0, 0, 3);
        checkOutput("stall overflow", 32'(overflow), 32'd1);
        checkOutput("stall f2y", 32'(f2y), 32'd0);
        holdCycles(1, 0, 0, 3);
        holdCycles(1, 0, 1, 6);
        checkOutput("drained valid", 32'(evt_valid), 32'd0);

        // drive cnt1 to saturation, then one more rise
        for (int i = 0; i < 700 && mCnt[0] < CMAX; i++) begin
            holdCycles(0, 0, 1, 2);
            holdCycles(1, 0, 1, 2);
        end
        checkOutput("sat reached", 32'(cnt1), 32'(CMAX));
        holdCycles(0, 0, 1, 2);
        holdCycles(1, 0, 1, 2);
        checkOutput("sat hold", 32'(cnt1), 32'(CMAX));

        // clear coinciding with a rise wins
        holdCycles(0, 0, 1, 2);
        applyStimulus(1, 0, 0, 1, 1);
        applyStimulus(1, 0, 1, 1, 1);
        checkOutput("clr cnt1", 32'(cnt1), 32'd0);
        checkOutput("clr overflow", 32'(overflow), 32'd0);

        // reset with three events queued and f1y high
        holdCycles(0, 0, 0, 3);
        holdCycles(1, 0, 0, 3);
        holdCycles(1, 1, 0, 3);
        checkOutput("pre-reset f1y", 32'(f1y), 32'd1);
        applyStimulus(1, 1, 0, 0, 0);
        checkOutput("post-reset valid", 32'(evt_valid), 32'd0);
        checkOutput("post-reset f1y", 32'(f1y), 32'd0);
        checkOutput("post-reset cnt1", 32'(cnt1), 32'd0);

        // random traffic
        curP1 = 0; curP2 = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 3) == 0) curP1 = ~curP1;
            if ($urandom_range(0, 3) == 0) curP2 = ~curP2;
            applyStimulus(curP1, curP2, ($urandom_range(0, 63) == 0),
                          ($urandom_range(0, 1) == 1), ($urandom_range(0, 499) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
